// File: rtl/dma_controller.sv
// -----------------------------------------------------------------------------
// dma_controller
//   Block-copy DMA engine that shares the 64 KB block RAM with the CPU.
//   The CPU programs source, destination, length and control through plain
//   stores to REG_BASE+0..+6. A start store halts the CPU (cpu_locked=0), and
//   the engine takes the memory port. It copies bytes in ascending order at
//   three cycles per byte (READ, WAIT, WRITE). It then returns the port and
//   pulses irq for one cycle.
//
// Ports
//   clock        in   1   system clock, all state changes on posedge
//   resetn       in   1   synchronous active-low reset
//   cpu_address  in   16  CPU bus address
//   cpu_o_data   in   8   CPU write data
//   cpu_we       in   1   CPU write strobe
//   cpu_locked   out  1   to CPU .locked; 0 halts the CPU
//   mem_address  out  16  block RAM address
//   mem_o_data   out  8   block RAM write data
//   mem_we       out  1   block RAM write enable
//   mem_i_data   in   8   block RAM read data, valid 1 cycle after address
//   busy         out  1   high from GRANT through the last WRITE
//   irq          out  1   one-cycle completion pulse
//
// Register map (write-only, captured only while IDLE; stores also reach RAM)
//   +0/+1 src lo/hi   +2/+3 dst lo/hi   +4/+5 len lo/hi
//   +6    ctrl: bit0 start, bit1 src_fixed, bit2 dst_fixed
// -----------------------------------------------------------------------------
module dma_controller #(
  parameter logic [15:0] REG_BASE = 16'hFF00
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_o_data,
  input  logic        cpu_we,
  output logic        cpu_locked,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_o_data,
  output logic        mem_we,
  input  logic [7:0]  mem_i_data,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic dst_fixed;
    logic src_fixed;
    logic start;
  } ctrl_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] src;
  logic [15:0] dst;
  logic [15:0] len;
  ctrl_t       ctrl;
  logic [7:0]  data_latch;

  // Offset of the CPU address from the register window. The subtraction keeps
  // the decode correct even if REG_BASE is not aligned to 8.
  logic [15:0] reg_off;
  logic        reg_hit;
  logic        start_hit;

  assign reg_off   = cpu_address - REG_BASE;
  assign reg_hit   = cpu_we && (reg_off < 16'd7);
  assign start_hit = reg_hit && (reg_off[2:0] == 3'd6) && cpu_o_data[0];

  // State register and datapath registers
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      ctrl       <= '0;
      data_latch <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (reg_hit) begin
            case (reg_off[2:0])
              3'd0:    src[7:0]  <= cpu_o_data;
              3'd1:    src[15:8] <= cpu_o_data;
              3'd2:    dst[7:0]  <= cpu_o_data;
              3'd3:    dst[15:8] <= cpu_o_data;
              3'd4:    len[7:0]  <= cpu_o_data;
              3'd5:    len[15:8] <= cpu_o_data;
              3'd6:    ctrl      <= ctrl_t'(cpu_o_data[2:0]);
              default: ;
            endcase
          end
        end
        S_WAIT:  data_latch <= mem_i_data;
        S_WRITE: begin
          // 16-bit adders wrap FFFF -> 0000 naturally.
          if (!ctrl.src_fixed) src <= src + 16'd1;
          if (!ctrl.dst_fixed) dst <= dst + 16'd1;
          len <= len - 16'd1;
        end
        S_DONE:  ctrl.start <= 1'b0;
        default: ;
      endcase
    end
  end

  // Next-state and memory-port steering
  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_next  = state;
    mem_address = cpu_address;
    mem_o_data  = cpu_o_data;
    mem_we      = 1'b0;
    busy        = 1'b0;
    cpu_locked  = 1'b1;
    irq         = 1'b0;

    case (state)
      S_IDLE: begin
        // The CPU owns the port. Register stores write through to RAM too.
        mem_we = cpu_we;
        if (start_hit) begin
          // A zero-length start skips the bus handover entirely.
          state_next = (len == 16'd0) ? S_DONE : S_GRANT;
        end
      end
      S_GRANT: begin
        // One dead cycle lets a CPU access already in flight complete.
        mem_address = src;
        busy        = 1'b1;
        cpu_locked  = 1'b0;
        state_next  = S_READ;
      end
      S_READ: begin
        mem_address = src;
        busy        = 1'b1;
        cpu_locked  = 1'b0;
        state_next  = S_WAIT;
      end
      S_WAIT: begin
        mem_address = src;
        busy        = 1'b1;
        cpu_locked  = 1'b0;
        state_next  = S_WRITE;
      end
      S_WRITE: begin
        mem_address = dst;
        mem_o_data  = data_latch;
        mem_we      = 1'b1;
        busy        = 1'b1;
        cpu_locked  = 1'b0;
        // len still holds its pre-decrement value in this cycle.
        state_next  = (len == 16'd1) ? S_DONE : S_READ;
      end
      S_DONE: begin
        irq        = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_controller.sv
// -----------------------------------------------------------------------------
// tb_dma_controller
//   Directed bench for dma_controller. A behavioural 64 KB RAM with one-cycle
//   registered read latency sits on the memory port. Inputs change 1 time unit
//   after posedge. Bus activity (locked cycles, irq pulses, DMA writes) is
//   sampled on negedge.
// -----------------------------------------------------------------------------
module tb_dma_controller;

  localparam logic [15:0] REG_BASE = 16'hFF00;

  logic        clock;
  logic        resetn;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_o_data;
  logic        cpu_we;
  logic        cpu_locked;
  logic [15:0] mem_address;
  logic [7:0]  mem_o_data;
  logic        mem_we;
  logic [7:0]  mem_i_data;
  logic        busy;
  logic        irq;

  int checks = 0;
  int errors = 0;

  dma_controller #(.REG_BASE(REG_BASE)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .cpu_address (cpu_address),
    .cpu_o_data  (cpu_o_data),
    .cpu_we      (cpu_we),
    .cpu_locked  (cpu_locked),
    .mem_address (mem_address),
    .mem_o_data  (mem_o_data),
    .mem_we      (mem_we),
    .mem_i_data  (mem_i_data),
    .busy        (busy),
    .irq         (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Block RAM model: synchronous write, registered read (1-cycle latency)
  logic [7:0] mem [0:65535];
  always @(posedge clock) begin
    if (mem_we) mem[mem_address] <= mem_o_data;
    mem_i_data <= mem[mem_address];
  end

  // Bus monitors
  int          locked_low = 0;
  int          irq_pulses = 0;
  int          dma_writes = 0;
  logic [15:0] wlog[$];
  always @(negedge clock) begin
    if (resetn) begin
      if (!cpu_locked) locked_low++;
      if (irq) irq_pulses++;
      if (mem_we && !cpu_locked) begin
        dma_writes++;
        wlog.push_back(mem_address);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One CPU store: driven for one full cycle and sampled at the following edge
  task automatic cpu_store(input logic [15:0] a, input logic [7:0] d);
    @(posedge clock);
    #1;
    cpu_address = a;
    cpu_o_data  = d;
    cpu_we      = 1'b1;
    @(posedge clock);
    #1;
    cpu_we = 1'b0;
  endtask

  task automatic program_regs(input logic [15:0] s, input logic [15:0] d,
                              input logic [15:0] l);
    cpu_store(REG_BASE + 16'd0, s[7:0]);
    cpu_store(REG_BASE + 16'd1, s[15:8]);
    cpu_store(REG_BASE + 16'd2, d[7:0]);
    cpu_store(REG_BASE + 16'd3, d[15:8]);
    cpu_store(REG_BASE + 16'd4, l[7:0]);
    cpu_store(REG_BASE + 16'd5, l[15:8]);
  endtask

  int lk0, irq0, wr0, wl0;

  task automatic snap();
    lk0  = locked_low;
    irq0 = irq_pulses;
    wr0  = dma_writes;
    wl0  = wlog.size();
  endtask

  initial begin
    resetn      = 1'b0;
    cpu_address = '0;
    cpu_o_data  = '0;
    cpu_we      = 1'b0;
    idle(3);

    // Reset state
    check("reset_locked", 32'(cpu_locked), 32'd1);
    check("reset_busy",   32'(busy),       32'd0);
    check("reset_irq",    32'(irq),        32'd0);
    check("reset_we",     32'(mem_we),     32'd0);
    resetn = 1'b1;
    idle(1);

    // 2: zero-length start (len is 0 out of reset)
    snap();
    cpu_store(REG_BASE + 16'd6, 8'h01);
    check("len0_irq_t1",  32'(irq),        32'd1);
    check("len0_locked",  32'(cpu_locked), 32'd1);
    check("len0_we",      32'(mem_we),     32'd0);
    idle(1);
    check("len0_irq_off", 32'(irq),        32'd0);
    idle(2);
    check("len0_nolock",  32'(locked_low - lk0), 32'd0);
    check("len0_pulses",  32'(irq_pulses - irq0), 32'd1);

    // 1: three-byte copy 1000 -> 2000, then a 1-byte follow-on from final src/dst
    cpu_store(16'h1000, 8'h11);
    cpu_store(16'h1001, 8'h22);
    cpu_store(16'h1002, 8'h33);
    cpu_store(16'h1003, 8'h44);
    program_regs(16'h1000, 16'h2000, 16'd3);
    snap();
    cpu_store(REG_BASE + 16'd6, 8'h01);
    check("t1_grant_locked", 32'(cpu_locked), 32'd0);
    check("t1_grant_busy",   32'(busy),       32'd1);
    idle(13);
    check("t1_byte0",  32'(mem[16'h2000]), 32'h11);
    check("t1_byte1",  32'(mem[16'h2001]), 32'h22);
    check("t1_byte2",  32'(mem[16'h2002]), 32'h33);
    check("t1_locked_cycles", 32'(locked_low - lk0), 32'd10);
    check("t1_irq_pulses",    32'(irq_pulses - irq0), 32'd1);
    check("t1_writes",        32'(dma_writes - wr0), 32'd3);
    check("t1_idle_locked",   32'(cpu_locked), 32'd1);
    cpu_store(REG_BASE + 16'd4, 8'h01);
    cpu_store(REG_BASE + 16'd5, 8'h00);
    cpu_store(REG_BASE + 16'd6, 8'h01);
    idle(7);
    check("t1_final_src_dst", 32'(mem[16'h2003]), 32'h44);

    // 3: source address wraps FFFF -> 0000
    cpu_store(16'hFFFE, 8'hA1);
    cpu_store(16'hFFFF, 8'hA2);
    cpu_store(16'h0000, 8'hA3);
    cpu_store(16'h0001, 8'hA4);
    cpu_store(16'h0002, 8'hA5);
    program_regs(16'hFFFE, 16'h0010, 16'd4);
    cpu_store(REG_BASE + 16'd6, 8'h01);
    idle(16);
    check("wrap_0010", 32'(mem[16'h0010]), 32'hA1);
    check("wrap_0011", 32'(mem[16'h0011]), 32'hA2);
    check("wrap_0012", 32'(mem[16'h0012]), 32'hA3);
    check("wrap_0013", 32'(mem[16'h0013]), 32'hA4);
    cpu_store(REG_BASE + 16'd4, 8'h01);
    cpu_store(REG_BASE + 16'd5, 8'h00);
    cpu_store(REG_BASE + 16'd6, 8'h01);
    idle(7);
    check("wrap_dst_0014", 32'(mem[16'h0014]), 32'hA5);

    // 4: dst_fixed, four writes to one address
    cpu_store(16'h3000, 8'hB0);
    cpu_store(16'h3001, 8'hB1);
    cpu_store(16'h3002, 8'hB2);
    cpu_store(16'h3003, 8'hB3);
    program_regs(16'h3000, 16'h4000, 16'd4);
    snap();
    cpu_store(REG_BASE + 16'd6, 8'h05);
    idle(16);
    check("fixed_value",  32'(mem[16'h4000]), 32'hB3);
    check("fixed_next",   32'(mem[16'h4001] === 8'hB1), 32'd0);
    check("fixed_writes", 32'(dma_writes - wr0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fixed_addr%0d", i), 32'(wlog[wl0 + i]), 32'h4000);
    end

    // 5: reset during the second byte's WAIT
    cpu_store(16'h5000, 8'hC0);
    cpu_store(16'h5001, 8'hC1);
    cpu_store(16'h6000, 8'hEE);
    cpu_store(16'h6001, 8'hEE);
    program_regs(16'h5000, 16'h6000, 16'd4);
    snap();
    cpu_store(REG_BASE + 16'd6, 8'h01);
    idle(5);
    check("rst_in_wait_locked", 32'(cpu_locked), 32'd0);
    check("rst_in_wait_we",     32'(mem_we),     32'd0);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    check("rst_locked",   32'(cpu_locked), 32'd1);
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_irq",      32'(irq),        32'd0);
    idle(4);
    check("rst_byte0",    32'(mem[16'h6000]), 32'hC0);
    check("rst_byte1",    32'(mem[16'h6001]), 32'hEE);
    check("rst_no_irq",   32'(irq_pulses - irq0), 32'd0);
    check("rst_writes",   32'(dma_writes - wr0), 32'd1);
    cpu_store(REG_BASE + 16'd6, 8'h01);
    check("rst_len_cleared", 32'(irq), 32'd1);
    idle(2);

    // 6: IDLE pass-through and a non-start ctrl store
    @(posedge clock);
    #1;
    cpu_address = 16'h0400;
    cpu_o_data  = 8'h5A;
    cpu_we      = 1'b1;
    #1;
    check("pt_we",   32'(mem_we),      32'd1);
    check("pt_addr", 32'(mem_address), 32'h0400);
    check("pt_data", 32'(mem_o_data),  32'h5A);
    @(posedge clock);
    #1;
    cpu_we = 1'b0;
    check("pt_mem", 32'(mem[16'h0400]), 32'h5A);
    program_regs(16'h0400, 16'h0500, 16'd2);
    snap();
    cpu_store(REG_BASE + 16'd6, 8'h00);
    check("nostart_locked", 32'(cpu_locked), 32'd1);
    check("nostart_busy",   32'(busy),       32'd0);
    check("nostart_irq",    32'(irq),        32'd0);
    check("nostart_mem",    32'(mem[REG_BASE + 16'd6]), 32'h00);
    idle(8);
    check("nostart_activity", 32'((locked_low - lk0) + (irq_pulses - irq0)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
